// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Constants and types shared by the accumulator CPU datapath.
//                Includes the datapath width, the register count, the
//                accumulator source select and the ALU opcode encodings
//                used by the decoder and the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int W        = 8;
    localparam int NUM_REGS = 16;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_IMM = 2'd2,
        SRC_REG = 2'd3
    } acc_src_t;

    // ALU opcodes, shared with the decoder and the ALU
    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b1010;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/flag_reg.sv
`default_nettype none
// ============================================================================
//  Module      : flag_reg
//  Description : Z/C/N/V status flags of the accumulator CPU.
//                C : clr_c forces 0 (beats carry_we), else carry_we loads alu_c.
//                Z/N : loaded from the ALU only on cmp_we.
//                V : loaded from the ALU on v_we.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                carry_we, cmp_we, v_we, clr_c - flag update controls
//                alu_c/z/n/v      - flag values from the ALU
//                c_out/z_out/n_out/v_out - current flag state
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_reg
(
    input  logic clk,
    input  logic reset,
    input  logic carry_we,
    input  logic cmp_we,
    input  logic v_we,
    input  logic clr_c,
    input  logic alu_c,
    input  logic alu_z,
    input  logic alu_n,
    input  logic alu_v,
    output logic c_out,
    output logic z_out,
    output logic n_out,
    output logic v_out
);

    logic r_c;
    logic r_z;
    logic r_n;
    logic r_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c <= 1'b0;
            r_z <= 1'b0;
            r_n <= 1'b0;
            r_v <= 1'b0;
        end else begin
            if (clr_c) begin
                r_c <= 1'b0;
            end else if (carry_we) begin
                r_c <= alu_c;
            end
            if (cmp_we) begin
                r_z <= alu_z;
                r_n <= alu_n;
            end
            if (v_we) begin
                r_v <= alu_v;
            end
        end
    end

    assign c_out = r_c;
    assign z_out = r_z;
    assign n_out = r_n;
    assign v_out = r_v;

endmodule : flag_reg
`default_nettype wire

// File: rtl/acc_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : acc_regfile
//  Description : Architectural state of the accumulator CPU: the accumulator,
//                the general register file and the status flags. Outputs are
//                read straight from state (no write-through bypass).
//  Ports       : clk, reset                - clock, synchronous active-high reset
//                rd_addr                   - register read / write select
//                acc_out, reg_out          - accumulator, reg[rd_addr]
//                c_out, z_out, n_out, v_out - status flags
//                acc_we, acc_src           - accumulator write and source
//                reg_we                    - write reg[rd_addr] with accumulator
//                alu_result, alu_c/z/n/v   - ALU result and flags
//                mem_data, imm             - load data, 5-bit immediate
//                carry_we, cmp_we, v_we, clr_c - flag update controls
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_regfile
    import cpu_pkg::*;
#(
    parameter int W        = cpu_pkg::W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [W-1:0]                acc_out,
    output logic [W-1:0]                reg_out,
    output logic                        c_out,
    output logic                        z_out,
    output logic                        n_out,
    output logic                        v_out,
    input  logic                        acc_we,
    input  logic [1:0]                  acc_src,
    input  logic                        reg_we,
    input  logic [W-1:0]                alu_result,
    input  logic                        alu_c,
    input  logic                        alu_z,
    input  logic                        alu_n,
    input  logic                        alu_v,
    input  logic [W-1:0]                mem_data,
    input  logic [4:0]                  imm,
    input  logic                        carry_we,
    input  logic                        cmp_we,
    input  logic                        v_we,
    input  logic                        clr_c
);

    logic [W-1:0] r_acc;
    logic [W-1:0] r_regs [NUM_REGS];

    acc_src_t     w_src;
    logic         w_addr_ok;
    logic [W-1:0] w_reg_rd;
    logic [W-1:0] w_acc_next;

    assign w_src     = acc_src_t'(acc_src);
    // Addresses beyond the populated registers read 0 and drop writes
    assign w_addr_ok = (32'(rd_addr) < NUM_REGS);
    assign w_reg_rd  = w_addr_ok ? r_regs[rd_addr] : '0;

    always_comb begin
        w_acc_next = alu_result;
        case (w_src)
            SRC_ALU: w_acc_next = alu_result;
            SRC_MEM: w_acc_next = mem_data;
            SRC_IMM: w_acc_next = {{(W-5){1'b0}}, imm};
            SRC_REG: w_acc_next = w_reg_rd;
            default: w_acc_next = alu_result;
        endcase
    end

    // Both writes use pre-edge values, so acc_we+SRC_REG+reg_we is a swap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (acc_we) begin
                r_acc <= w_acc_next;
            end
            if (reg_we && w_addr_ok) begin
                r_regs[rd_addr] <= r_acc;
            end
        end
    end

    assign acc_out = r_acc;
    assign reg_out = w_reg_rd;

    flag_reg u_flag_reg (
        .clk      (clk),
        .reset    (reset),
        .carry_we (carry_we),
        .cmp_we   (cmp_we),
        .v_we     (v_we),
        .clr_c    (clr_c),
        .alu_c    (alu_c),
        .alu_z    (alu_z),
        .alu_n    (alu_n),
        .alu_v    (alu_v),
        .c_out    (c_out),
        .z_out    (z_out),
        .n_out    (n_out),
        .v_out    (v_out)
    );

endmodule : acc_regfile
`default_nettype wire

// File: doc/acc_regfile.md
Name: acc_regfile

Overview:
- Architectural state stage for the accumulator CPU datapath. Holds the 8-bit accumulator, a 16-entry general register file and the Z/C/N/V flag register.
- Feeds the ALU's accumulator, register and carry-in operands.
- Captures ALU results and flags at the clock edge: writeback from the ALU, data memory or an immediate, plus moves between the accumulator and registers.

Parameters:
- W, 8, datapath width of the accumulator and registers.
- NUM_REGS, 16, number of general registers; the address width is $clog2(NUM_REGS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_addr  input  4  register selected for reg_out and as the register write target.
- acc_out  output  W  current accumulator; ALU acc_in.
- reg_out  output  W  reg[rd_addr]; ALU reg_in.
- c_out  output  1  carry flag; ALU c_in.
- z_out, n_out, v_out  output  1 each  zero, negative and overflow flags, used by the branch unit.
- acc_we  input  1  write the accumulator this cycle.
- acc_src  input  2  accumulator source: 0 ALU, 1 MEM, 2 IMM, 3 REG (reg[rd_addr]).
- reg_we  input  1  write reg[rd_addr] with the accumulator.
- alu_result  input  W  ALU OUT.
- alu_c, alu_z, alu_n, alu_v  input  1 each  ALU flag outputs.
- mem_data  input  W  load data.
- imm  input  5  immediate, zero-extended to W.
- carry_we  input  1  capture alu_c (add/sub only).
- cmp_we  input  1  capture alu_z and alu_n (compare only).
- v_we  input  1  capture alu_v.
- clr_c  input  1  force C to 0.

Behaviour:
- Reset (synchronous): on a rising edge with reset=1, the accumulator, all registers and all four flags become 0. This overrides every write enable in the same cycle. After reset, acc_out, reg_out, c_out, z_out, n_out and v_out all read 0.
- Reads: acc_out, reg_out and the flag outputs are combinational from state. There is no write-through bypass: a write in cycle k is visible on the outputs after the edge ending cycle k.
- Accumulator write: when acc_we=1, the accumulator takes the source selected by acc_src:
  - ALU: alu_result.
  - MEM: mem_data.
  - IMM: {3'b0, imm}.
  - REG: reg[rd_addr], i.e. the pre-edge value.
- Register write: when reg_we=1, reg[rd_addr] takes the pre-edge accumulator.
- Simultaneous acc_we=1, acc_src=REG and reg_we=1: the two values swap (acc gets old reg, reg gets old acc). This is a legal swap idiom.
- Simultaneous acc_we with another acc_src and reg_we: reg gets the old accumulator and acc gets the new value.
- C flag:
  - clr_c=1 forces C to 0 and overrides carry_we.
  - Otherwise carry_we=1 loads alu_c.
  - Otherwise C holds.
- Z/N flags: load alu_z and alu_n only when cmp_we=1, otherwise hold. ALU results never update them implicitly.
- V flag: loads alu_v when v_we=1, otherwise holds.
- Flag enables are independent of acc_we; all of them may assert in the same cycle.
- Address range: rd_addr values at or above NUM_REGS read 0 and ignore writes.
- Latency: one cycle from enable to visible state. No stalls and no handshake; the decoder guarantees that enables are valid whenever reset=0.
- X-safety: all state is reset, so no output is X after the first reset edge.

Decomposition:
- Shared package cpu_pkg:
  - W and NUM_REGS constants.
  - typedef enum logic[1:0] acc_src_t {SRC_ALU, SRC_MEM, SRC_IMM, SRC_REG}.
  - ALU opcode constants (ADD=4'b0010, SUB=4'b0011, CMP=4'b1010, ...) shared with the decoder and ALU.
- One sub-module, flag_reg: holds Z/C/N/V with the carry_we/cmp_we/v_we/clr_c priority rules. The accumulator and register array stay in acc_regfile.

Test Plan:
- Reset: write acc=0x5A and reg[3]=0x5A, assert reset for 1 cycle -> acc_out=0, reg_out(rd_addr=3)=0, all flags 0. Repeat with acc_we=1 in the reset cycle -> acc stays 0.
- Immediate load and store: acc_src=IMM, imm=5'h1F, acc_we -> acc_out=0x1F next cycle; then reg_we with rd_addr=7 -> reg_out=0x1F at rd_addr=7 and 0 at rd_addr=6.
- Swap: acc=0x11, reg[2]=0x22, then acc_we+REG+reg_we with rd_addr=2 -> acc_out=0x22, reg_out=0x11.
- Carry: alu_c=1 with carry_we -> c_out=1. Next cycle clr_c=1 and carry_we=1 with alu_c=1 -> c_out=0. Next cycle no enables -> c_out holds 0.
- Compare flags:
  - cmp_we with alu_z=0, alu_n=1 -> z_out=0, n_out=1.
  - Then an ALU write with alu_z=1 and cmp_we=0 -> flags unchanged.
  - Then cmp_we with alu_z=1, alu_n=0 -> z_out=1, n_out=0.
- No bypass: in the same cycle drive acc_we (ALU, alu_result=0xFF) and sample acc_out -> acc_out shows the old value 0x1F; it shows 0xFF after the edge. Also drive mem_data=0x80 with acc_src=MEM -> acc_out=0x80.
